// File: rtl/ps2_host_port_pkg.sv
// ============================================================================
// Module  : ps2_host_port_pkg
// Brief   : Shared types and constants for the PS/2 host port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_host_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RX          = 3'd1,
        ST_TX_INH      = 3'd2,
        ST_TX_REL      = 3'd3,
        ST_TX_SHIFT    = 3'd4,
        ST_TX_ACK      = 3'd5,
        ST_TX_WAITIDLE = 3'd6
    } state_t;

    localparam int         FRAME_BITS   = 11;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // Parity bit that makes data+parity contain an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
// ============================================================================
// Module  : ps2_rx_fifo
// Brief   : Read-first synchronous FIFO with a registered head output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr, w_rd_next;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;
    logic             w_push_ok, w_pop_ok;

    assign valid     = (r_count != '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign head_data = r_head;
    assign w_pop_ok  = pop & valid;
    assign w_push_ok = push & (~full | w_pop_ok);
    assign w_rd_next = r_rd_ptr + PTR_W'(w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_rd_ptr <= w_rd_next;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count  <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
            // New head is the incoming byte when it lands on the next read slot.
            if (w_push_ok && (r_wr_ptr == w_rd_next)) r_head <= push_data;
            else                                     r_head <= r_mem[w_rd_next];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_host_port.sv
// ============================================================================
// Module  : ps2_host_port
// Brief   : Bidirectional PS/2 host port with RX FIFO, TX with ACK, watchdog.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_port
    import ps2_host_port_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int INHIBIT_CYC = 2500,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_err,
    output logic       rx_overflow,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy
);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int INH_W = $clog2(INHIBIT_CYC + 1);

    logic                  r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [FILTER_LEN-1:0] r_clk_hist;
    logic                  r_clk_filt, r_clk_filt_d;
    logic                  w_fall;

    state_t           r_state, w_state;
    logic [3:0]       r_bit_cnt, w_bit_cnt;
    logic [8:0]       r_shift, w_shift;
    logic [WD_W-1:0]  r_wdog, w_wdog;
    logic [INH_W-1:0] r_inh, w_inh;
    logic             r_clk_oe, w_clk_oe, r_data_oe, w_data_oe;
    logic             r_rx_err, w_rx_err, r_tx_err, w_tx_err;
    logic             r_tx_done, w_tx_done, r_rx_ovf, w_rx_ovf;
    logic             r_tx_ready;
    logic             w_timeout, w_push, w_pop, w_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_dat_s1     <= 1'b1;
            r_dat_s2     <= 1'b1;
            r_clk_hist   <= '1;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
        end else begin
            r_clk_s1     <= ps2_clk_i;
            r_clk_s2     <= r_clk_s1;
            r_dat_s1     <= ps2_data_i;
            r_dat_s2     <= r_dat_s1;
            r_clk_hist   <= {r_clk_hist[FILTER_LEN-2:0], r_clk_s2};
            if (&r_clk_hist)       r_clk_filt <= 1'b1;
            else if (~|r_clk_hist) r_clk_filt <= 1'b0;
            r_clk_filt_d <= r_clk_filt;
        end
    end

    assign w_fall = r_clk_filt_d & ~r_clk_filt;

    always_comb begin
        w_state   = r_state;
        w_bit_cnt = r_bit_cnt;
        w_shift   = r_shift;
        w_inh     = r_inh;
        w_clk_oe  = r_clk_oe;
        w_data_oe = r_data_oe;
        w_rx_err  = 1'b0;
        w_tx_err  = 1'b0;
        w_tx_done = 1'b0;
        w_push    = 1'b0;
        // Watchdog only measures gaps once the bus belongs to the device.
        w_wdog    = (r_state == ST_IDLE || r_state == ST_TX_INH || w_fall) ? '0 : r_wdog + 1'b1;
        w_timeout = (r_state != ST_IDLE) && (r_state != ST_TX_INH) && !w_fall &&
                    (r_wdog == WD_W'(TIMEOUT_CYC - 1));
        unique case (r_state)
            ST_IDLE: begin
                w_clk_oe  = 1'b0;
                w_data_oe = 1'b0;
                if (tx_valid && r_tx_ready) begin
                    w_shift  = {odd_parity(tx_data), tx_data};
                    w_inh    = '0;
                    w_clk_oe = 1'b1;
                    w_state  = ST_TX_INH;
                end else if (w_fall && !r_dat_s2) begin
                    w_bit_cnt = '0;
                    w_state   = ST_RX;
                end
            end
            ST_RX: if (w_fall) begin
                if (r_bit_cnt == 4'(FRAME_BITS - 2)) begin
                    if ((^r_shift) && r_dat_s2) w_push   = 1'b1;
                    else                        w_rx_err = 1'b1;
                    w_state = ST_IDLE;
                end else begin
                    w_shift   = {r_dat_s2, r_shift[8:1]};
                    w_bit_cnt = r_bit_cnt + 4'd1;
                end
            end
            ST_TX_INH: begin
                w_clk_oe = 1'b1;
                if (r_inh == INH_W'(INHIBIT_CYC - 1)) begin
                    w_data_oe = 1'b1;
                    w_state   = ST_TX_REL;
                end else begin
                    w_inh = r_inh + 1'b1;
                end
            end
            ST_TX_REL: begin
                w_clk_oe  = 1'b0;
                w_bit_cnt = '0;
                w_state   = ST_TX_SHIFT;
            end
            ST_TX_SHIFT: if (w_fall) begin
                if (r_bit_cnt == 4'(FRAME_BITS - 2)) begin
                    w_data_oe = 1'b0;
                    w_state   = ST_TX_ACK;
                end else begin
                    w_data_oe = ~r_shift[0];
                    w_shift   = {1'b0, r_shift[8:1]};
                    w_bit_cnt = r_bit_cnt + 4'd1;
                end
            end
            ST_TX_ACK: if (w_fall) begin
                if (!r_dat_s2) w_tx_done = 1'b1;
                else           w_tx_err  = 1'b1;
                w_state = ST_TX_WAITIDLE;
            end
            ST_TX_WAITIDLE: if (r_clk_filt && r_dat_s2) w_state = ST_IDLE;
            default: w_state = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_state   = ST_IDLE;
            w_clk_oe  = 1'b0;
            w_data_oe = 1'b0;
            w_push    = 1'b0;
            w_tx_done = 1'b0;
            w_rx_err  = (r_state == ST_RX);
            w_tx_err  = (r_state != ST_RX);
        end
    end

    assign w_pop    = rx_valid & rx_ready;
    assign w_rx_ovf = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_wdog     <= '0;
            r_inh      <= '0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_rx_err   <= 1'b0;
            r_tx_err   <= 1'b0;
            r_tx_done  <= 1'b0;
            r_rx_ovf   <= 1'b0;
            r_tx_ready <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_bit_cnt  <= w_bit_cnt;
            r_shift    <= w_shift;
            r_wdog     <= w_wdog;
            r_inh      <= w_inh;
            r_clk_oe   <= w_clk_oe;
            r_data_oe  <= w_data_oe;
            r_rx_err   <= w_rx_err;
            r_tx_err   <= w_tx_err;
            r_tx_done  <= w_tx_done;
            r_rx_ovf   <= w_rx_ovf;
            r_tx_ready <= (w_state == ST_IDLE);
        end
    end

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (r_shift[7:0]),
        .pop       (w_pop),
        .head_data (rx_data),
        .valid     (rx_valid),
        .full      (w_full)
    );

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign rx_err      = r_rx_err;
    assign rx_overflow = r_rx_ovf;
    assign tx_ready    = r_tx_ready;
    assign tx_done     = r_tx_done;
    assign tx_err      = r_tx_err;
    assign busy        = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_port.sv
// ============================================================================
// Module  : tb_ps2_host_port
// Brief   : Self-checking bench with a PS/2 device model and reference queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_host_port;
    localparam int FILTER_LEN  = 4;
    localparam int FIFO_DEPTH  = 8;
    localparam int INHIBIT_CYC = 40;
    localparam int TIMEOUT_CYC = 600;
    localparam int HP          = 30;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       dev_clk = 1'b1, dev_data = 1'b1;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready = 1'b0, rx_err, rx_overflow;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0, tx_ready, tx_done, tx_err, busy;
    wire        ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
    wire        ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_host_port #(
        .FILTER_LEN  (FILTER_LEN),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .INHIBIT_CYC (INHIBIT_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_clk_i   (ps2_clk_line),
        .ps2_data_i  (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_err      (rx_err),
        .rx_overflow (rx_overflow),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int n_rx_err = 0, n_ovf = 0, n_tx_done = 0, n_tx_err = 0;
    int e_rx_err = 0, e_ovf = 0, e_tx_done = 0, e_tx_err = 0;
    logic [7:0] model_q[$];

    always @(negedge clk) begin
        if (rx_err)      n_rx_err++;
        if (rx_overflow) n_ovf++;
        if (tx_done)     n_tx_done++;
        if (tx_err)      n_tx_err++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Device-to-host frame; nbits < 11 truncates the frame.
    task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^d) ^ flip_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_data = f[i];
            wait_cyc(HP);
            dev_clk = 1'b0;
            wait_cyc(HP);
            dev_clk = 1'b1;
        end
        wait_cyc(HP);
        dev_data = 1'b1;
    endtask

    // Reference model: decides frame outcome from the bits on the wire.
    task automatic model_frame(input logic [7:0] d, input bit flip_par, input bit bad_stop);
        logic par;
        par = (~^d) ^ flip_par;
        if (($countones({par, d}) % 2 == 1) && !bad_stop) begin
            if (model_q.size() == FIFO_DEPTH) e_ovf++;
            else model_q.push_back(d);
        end else begin
            e_rx_err++;
        end
    endtask

    task automatic drain();
        int guard;
        while (model_q.size() > 0) begin
            guard = 0;
            while (!rx_valid && guard < 50) begin wait_cyc(1); guard++; end
            check("rx_data_pop", {24'd0, rx_data}, {24'd0, model_q.pop_front()});
            rx_ready = 1'b1;
            wait_cyc(1);
            rx_ready = 1'b0;
        end
        check("rx_valid_after_drain", {31'd0, rx_valid}, 32'd0);
    endtask

    task automatic start_tx(input logic [7:0] d);
        int guard;
        guard = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && guard < 2000) begin wait_cyc(1); guard++; end
        if (guard >= 2000) begin errors++; $display("FAIL tx_accept: tx_ready stuck at 0, required 1"); end
        wait_cyc(1);
        tx_valid = 1'b0;
    endtask

    // Host-to-device receiver: measures inhibit, clocks out 11 bits, optional ACK.
    task automatic dev_receive(input bit ack, output logic [7:0] d, output logic par,
                               output logic stop, output int inh, output logic start_ok);
        int guard;
        guard = 0;
        d = 8'h00; par = 1'b0; stop = 1'b0;
        while (!ps2_clk_oe && guard < 1000) begin wait_cyc(1); guard++; end
        inh = 0;
        while (ps2_clk_oe && guard < 5000) begin inh++; guard++; wait_cyc(1); end
        start_ok = ps2_data_oe;
        wait_cyc(HP);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) dev_data = 1'b0;
            dev_clk = 1'b0;
            wait_cyc(HP);
            if (k <= 8)       d[k-1] = ps2_data_line;
            else if (k == 9)  par    = ps2_data_line;
            else if (k == 10) stop   = ps2_data_line;
            dev_clk = 1'b1;
            wait_cyc(HP);
        end
        dev_data = 1'b1;
    endtask

    task automatic tx_test(input logic [7:0] d, input bit ack);
        logic [7:0] got;
        logic par, stop, start_ok;
        int inh;
        start_tx(d);
        dev_receive(ack, got, par, stop, inh, start_ok);
        if (ack) e_tx_done++; else e_tx_err++;
        wait_cyc(20);
        check("tx_inhibit_long_enough", {31'd0, inh >= INHIBIT_CYC}, 32'd1);
        check("tx_start_bit", {31'd0, start_ok}, 32'd1);
        check("tx_bits", {24'd0, got}, {24'd0, d});
        check("tx_parity", {31'd0, par}, {31'd0, ($countones(d) % 2 == 0)});
        check("tx_stop", {31'd0, stop}, 32'd1);
        check("tx_done_count", n_tx_done, e_tx_done);
        check("tx_err_count", n_tx_err, e_tx_err);
        check("busy_after_tx", {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         flip_par;
        bit         bad_stop;
        bit         exp_good;
    } rx_vec_t;

    initial begin
        rx_vec_t vec[5];
        int cyc;
        logic [7:0] rd;
        bit fp, bs;
        int r;

        vec[0] = '{8'h1C, 1'b0, 1'b0, 1'b1};
        vec[1] = '{8'h1C, 1'b1, 1'b0, 1'b0};
        vec[2] = '{8'hA5, 1'b0, 1'b1, 1'b0};
        vec[3] = '{8'h00, 1'b0, 1'b0, 1'b1};
        vec[4] = '{8'hFF, 1'b0, 1'b0, 1'b1};

        // Reset state
        wait_cyc(4);
        check("rst_clk_oe",   {31'd0, ps2_clk_oe},  32'd0);
        check("rst_data_oe",  {31'd0, ps2_data_oe}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid},    32'd0);
        check("rst_tx_ready", {31'd0, tx_ready},    32'd0);
        check("rst_busy",     {31'd0, busy},        32'd0);
        check("rst_pulses",   {28'd0, rx_err, rx_overflow, tx_done, tx_err}, 32'd0);
        reset_n = 1'b1;
        wait_cyc(1);
        check("tx_ready_after_reset", {31'd0, tx_ready}, 32'd1);

        // Table-driven RX frames
        for (int i = 0; i < 5; i++) begin
            send_frame(vec[i].data, vec[i].flip_par, vec[i].bad_stop, 11);
            wait_cyc(10);
            if (!vec[i].exp_good) e_rx_err++;
            check("tbl_rx_err", n_rx_err, e_rx_err);
            check("tbl_rx_valid", {31'd0, rx_valid}, {31'd0, vec[i].exp_good});
            if (vec[i].exp_good) begin
                check("tbl_rx_data", {24'd0, rx_data}, {24'd0, vec[i].data});
                rx_ready = 1'b1; wait_cyc(1); rx_ready = 1'b0;
            end
        end

        // Overflow: nine good frames, consumer stalled
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 11);
            model_frame(8'(i), 1'b0, 1'b0);
        end
        wait_cyc(10);
        check("ovf_count", n_ovf, e_ovf);
        check("ovf_exp_one", e_ovf, 1);
        drain();

        // Randomised frames against the reference model
        for (int i = 0; i < 12; i++) begin
            rd = 8'($urandom);
            r  = $urandom_range(0, 7);
            fp = (r < 2);
            bs = (r == 2);
            send_frame(rd, fp, bs, 11);
            model_frame(rd, fp, bs);
            wait_cyc(10);
            check("rnd_rx_err", n_rx_err, e_rx_err);
            check("rnd_ovf", n_ovf, e_ovf);
            check("rnd_rx_valid", {31'd0, rx_valid}, {31'd0, model_q.size() != 0});
            if (model_q.size() != 0)
                check("rnd_head", {24'd0, rx_data}, {24'd0, model_q[0]});
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        // RX watchdog: clock stops after 4 bits, then a good frame
        send_frame(8'h55, 1'b0, 1'b0, 4);
        e_rx_err++;
        wait_cyc(TIMEOUT_CYC + 100);
        check("rx_timeout_err", n_rx_err, e_rx_err);
        check("rx_timeout_empty", {31'd0, rx_valid}, 32'd0);
        check("rx_timeout_idle", {31'd0, busy}, 32'd0);
        send_frame(8'hF0, 1'b0, 1'b0, 11);
        model_frame(8'hF0, 1'b0, 1'b0);
        wait_cyc(10);
        check("rx_after_timeout_err", n_rx_err, e_rx_err);
        drain();

        // Host-to-device transfers
        tx_test(8'hED, 1'b1);
        tx_test(8'($urandom), 1'($urandom_range(0, 1)));

        // TX where the device never clocks
        start_tx(8'hFF);
        cyc = 0;
        while (!ps2_clk_oe && cyc < 1000) begin wait_cyc(1); cyc++; end
        while (ps2_clk_oe && cyc < 2000) begin wait_cyc(1); cyc++; end
        e_tx_err++;
        cyc = 0;
        while (n_tx_err != e_tx_err && cyc < TIMEOUT_CYC + 200) begin wait_cyc(1); cyc++; end
        check("tx_timeout_err", n_tx_err, e_tx_err);
        check("tx_timeout_window", {31'd0, (cyc >= TIMEOUT_CYC - 10) && (cyc <= TIMEOUT_CYC + 10)}, 32'd1);
        check("tx_timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("tx_timeout_idle", {31'd0, busy}, 32'd0);
        wait_cyc(20);

        // Asynchronous reset during inhibit releases the clock line at once
        start_tx(8'hF4);
        wait_cyc(5);
        check("inh_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(5);
        check("post_rst_tx_ready", {31'd0, tx_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
